// File: rtl/inst_fetch_queue.sv
// Instruction prefetch queue: fetches aligned 32-bit words from instruction
// memory, buffers them as halfwords in a circular queue and hands decode one
// RV32C or RV32I instruction per cycle, including words-spanning 32-bit ones.
// Redirects flush the queue and restart fetch; stale responses are dropped.
module inst_fetch_queue #(
    parameter int              AW       = 32,
    parameter int              DEPTH    = 8,
    parameter logic [AW-1:0]   RESET_PC = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic                          mem_req,
    output logic [AW-1:0]                 mem_addr,
    input  logic                          mem_ack,
    input  logic [31:0]                   mem_rdata,
    input  logic                          redirect_valid,
    input  logic [AW-1:0]                 redirect_pc,
    output logic                          inst_valid,
    input  logic                          inst_ready,
    output logic [31:0]                   inst_out,
    output logic [AW-1:0]                 inst_pc,
    output logic                          inst_is_c,
    output logic [$clog2(DEPTH+1)-1:0]    q_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] RESET_FETCH = {RESET_PC[AW-1:2], 2'b00};

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t         state;
    state_t         state_next;

    logic [15:0]    queue [DEPTH];
    logic [PW-1:0]  head;
    logic [PW-1:0]  tail;
    logic [CW-1:0]  count;
    logic [AW-1:0]  fetch_addr;
    logic [AW-1:0]  req_addr;
    logic           skip;

    logic [15:0]    h0;
    logic [15:0]    h1;
    logic           head_c;
    logic           room;
    logic           accept;
    logic           fire;
    logic [CW-1:0]  push_n;
    logic [CW-1:0]  pop_n;

    // Head halfwords; the queue depth is a power of two so head+1 wraps for free.
    assign h0      = queue[head];
    assign h1      = queue[head + PW'(1)];
    assign head_c  = (h0[1:0] != 2'b11);
    assign room    = (count <= CW'(DEPTH - 2));
    assign fire    = inst_valid & inst_ready;
    assign push_n  = accept ? (skip ? CW'(1) : CW'(2)) : '0;
    assign pop_n   = fire ? (head_c ? CW'(1) : CW'(2)) : '0;
    assign q_count = count;

    // Fetch FSM next-state and memory handshake outputs.
    always_comb begin
        state_next = state;
        mem_req    = 1'b0;
        mem_addr   = fetch_addr;
        accept     = 1'b0;
        case (state)
            RUN: begin
                // Only issue when a full word is guaranteed to fit on return.
                mem_req = room;
                accept  = room & mem_ack;
                if (room && !mem_ack) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                mem_req  = 1'b1;
                mem_addr = req_addr;
                accept   = mem_ack;
                if (mem_ack) begin
                    state_next = RUN;
                end
            end
            DRAIN: begin
                mem_req  = 1'b1;
                mem_addr = req_addr;
                if (mem_ack) begin
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
        if (redirect_valid) begin
            // Any response this cycle belongs to the old stream.
            accept     = 1'b0;
            state_next = (mem_req && !mem_ack) ? DRAIN : RUN;
        end
        if (rst) begin
            mem_req = 1'b0;
        end
    end

    // Decode view of the queue head.
    always_comb begin
        inst_out   = '0;
        inst_is_c  = 1'b0;
        inst_valid = 1'b0;
        if (count != '0) begin
            inst_is_c  = head_c;
            inst_out   = head_c ? {16'h0000, h0} : {h1, h0};
            inst_valid = !redirect_valid && (head_c || count >= CW'(2));
        end
    end

    // Control state: FSM, pointers, occupancy, fetch/decode PCs and skip flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RUN;
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            fetch_addr <= RESET_FETCH;
            req_addr   <= RESET_FETCH;
            inst_pc    <= RESET_PC;
            skip       <= RESET_PC[1];
        end else begin
            state <= state_next;
            // Captures the address being requested so it survives a redirect.
            if (state == RUN) begin
                req_addr <= fetch_addr;
            end
            if (redirect_valid) begin
                head       <= '0;
                tail       <= '0;
                count      <= '0;
                inst_pc    <= redirect_pc;
                fetch_addr <= {redirect_pc[AW-1:2], 2'b00};
                skip       <= redirect_pc[1];
            end else begin
                head  <= head + PW'(pop_n);
                tail  <= tail + PW'(push_n);
                count <= count + push_n - pop_n;
                if (fire) begin
                    inst_pc <= inst_pc + (head_c ? AW'(2) : AW'(4));
                end
                if (accept) begin
                    fetch_addr <= fetch_addr + AW'(4);
                    skip       <= 1'b0;
                end
            end
        end
    end

    // Halfword storage; an unaligned restart drops the lower half of the first word.
    always_ff @(posedge clk) begin
        if (accept) begin
            if (skip) begin
                queue[tail] <= mem_rdata[31:16];
            end else begin
                queue[tail]          <= mem_rdata[15:0];
                queue[tail + PW'(1)] <= mem_rdata[31:16];
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: a memory model with selectable latency, random
// ready/redirect stimulus, and a scoreboard fed from a PC-walking reference.
module tb_inst_fetch_queue;
    localparam int AW    = 32;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            mem_req;
    logic [AW-1:0]   mem_addr;
    logic            mem_ack = 1'b0;
    logic [31:0]     mem_rdata = '0;
    logic            redirect_valid = 1'b0;
    logic [AW-1:0]   redirect_pc = '0;
    logic            inst_valid;
    logic            inst_ready = 1'b0;
    logic [31:0]     inst_out;
    logic [AW-1:0]   inst_pc;
    logic            inst_is_c;
    logic [CW-1:0]   q_count;

    inst_fetch_queue #(.AW(AW), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_out       (inst_out),
        .inst_pc        (inst_pc),
        .inst_is_c      (inst_is_c),
        .q_count        (q_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] pc;
        logic [31:0]   inst;
        logic          is_c;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          mon_e;
    logic [AW-1:0] gen_pc = '0;
    logic [31:0]   mem [256];
    int            total = 0;
    int            bad   = 0;

    bit            pend = 1'b0;
    logic [AW-1:0] paddr = '0;
    int            lat = 0;
    int            lat_mode = 0;
    logic [AW-1:0] issued_q[$];
    int            ready_pct = 100;
    int            redir_pct = 0;
    int            idle = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [15:0] hw(input logic [AW-1:0] a);
        logic [31:0] w;
        w = mem[a[9:2]];
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    function automatic logic [31:0] word(input logic [AW-1:0] a);
        return mem[a[9:2]];
    endfunction

    // Reference: walk the program from gen_pc, one instruction at a time.
    task automatic push_exp();
        exp_t e;
        logic [15:0] lo;
        lo   = hw(gen_pc);
        e.pc = gen_pc;
        if (lo[1:0] != 2'b11) begin
            e.inst = {16'h0000, lo};
            e.is_c = 1'b1;
            gen_pc = gen_pc + 32'd2;
        end else begin
            e.inst = {hw(gen_pc + 32'd2), lo};
            e.is_c = 1'b0;
            gen_pc = gen_pc + 32'd4;
        end
        exp_q.push_back(e);
    endtask

    task automatic restart(input logic [AW-1:0] pc);
        exp_q.delete();
        gen_pc = pc;
        idle   = 0;
    endtask

    task automatic do_redirect(input logic [AW-1:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        restart(pc);
        issued_q.delete();
    endtask

    function automatic int pick_lat();
        if (lat_mode == 0) return 0;
        if (lat_mode == 1) return int'($urandom_range(0, 3));
        return 3;
    endfunction

    // One cycle of memory model and input stimulus, called just after posedge.
    task automatic drive();
        mem_ack = 1'b0;
        if (rst) begin
            if (pend) begin
                if (lat == 0) begin
                    mem_ack   = 1'b1;
                    mem_rdata = word(paddr);
                    pend      = 1'b0;
                end else begin
                    lat--;
                end
            end
        end else if (mem_req) begin
            if (!pend) begin
                chk("issue_guard", 32'(q_count <= CW'(DEPTH - 2)), 32'd1);
                chk("addr_align", 32'(mem_addr[1:0]), 32'd0);
                pend  = 1'b1;
                paddr = mem_addr;
                issued_q.push_back(mem_addr);
                lat   = pick_lat();
            end else begin
                chk("addr_hold", mem_addr, paddr);
            end
            if (lat == 0) begin
                mem_ack   = 1'b1;
                mem_rdata = word(paddr);
                pend      = 1'b0;
            end else begin
                lat--;
            end
        end else if (pend) begin
            chk("req_held", 32'(mem_req), 32'd1);
            pend = 1'b0;
        end
        inst_ready     = (int'($urandom_range(0, 99)) < ready_pct);
        redirect_valid = 1'b0;
        if (!rst && int'($urandom_range(0, 99)) < redir_pct) begin
            do_redirect(AW'($urandom_range(0, 511) * 2));
        end
        while (exp_q.size() < 8) push_exp();
        if (!rst && inst_ready) begin
            idle++;
            if (idle > 40) begin
                total++;
                bad++;
                $display("FAIL progress: got no instruction for %0d ready cycles, want fewer than 40", idle);
                idle = 0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic wait_valid(input string name);
        for (int k = 0; k < 30; k++) begin
            step();
            if (inst_valid) return;
        end
        total++;
        bad++;
        $display("FAIL %s: got inst_valid=0 after 30 cycles, want 1", name);
    endtask

    // Scoreboard monitor: compares every accepted instruction against the model.
    always @(negedge clk) begin
        if (!rst) begin
            chk("count_le_depth", 32'(q_count <= CW'(DEPTH)), 32'd1);
            if (redirect_valid) chk("valid_in_redirect", 32'(inst_valid), 32'd0);
            if (inst_valid && inst_ready) begin
                idle = 0;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_empty: got inst %h at pc %h, want no instruction", inst_out, inst_pc);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("inst_pc", inst_pc, mon_e.pc);
                    chk("inst_out", inst_out, mon_e.inst);
                    chk("inst_is_c", 32'(inst_is_c), 32'(mon_e.is_c));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[0] = 32'h0050_0093;
        mem[1] = 32'h00A0_0113;
        mem[2] = 32'h0093_4505;
        mem[3] = 32'h1234_0050;

        // Reset values.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_inst_out", inst_out, 32'h0);
        chk("rst_inst_is_c", 32'(inst_is_c), 32'd0);
        chk("rst_q_count", 32'(q_count), 32'd0);

        // Release, zero-wait memory: one cycle of fetch latency.
        lat_mode  = 0;
        ready_pct = 100;
        @(posedge clk);
        #1;
        rst = 1'b0;
        restart(32'h0);
        #1;
        chk("first_req", 32'(mem_req), 32'd1);
        chk("first_addr", mem_addr, 32'h0);
        drive();
        step();
        chk("c1_valid", 32'(inst_valid), 32'd1);
        chk("c1_inst", inst_out, 32'h0050_0093);
        chk("c1_pc", inst_pc, 32'h0);
        step();
        chk("c2_pc", inst_pc, 32'h4);
        chk("c2_inst", inst_out, 32'h00A0_0113);

        // Mixed compressed / word-spanning stream at 0x8.
        step();
        do_redirect(32'h8);
        wait_valid("mix_wait");
        chk("mix_c_inst", inst_out, 32'h0000_4505);
        chk("mix_c_is_c", 32'(inst_is_c), 32'd1);
        chk("mix_c_pc", inst_pc, 32'h8);
        step();
        chk("mix_span_inst", inst_out, 32'h0050_0093);
        chk("mix_span_pc", inst_pc, 32'hA);

        // Decode stalled: queue fills, fetch throttles.
        step();
        do_redirect(32'h40);
        ready_pct = 0;
        repeat (15) step();
        chk("full_count", 32'(q_count), 32'(DEPTH));
        chk("full_no_req", 32'(mem_req), 32'd0);
        ready_pct = 100;
        repeat (20) step();

        // Redirect with a slow request in flight: stale word discarded.
        lat_mode = 2;
        for (int k = 0; k < 20 && !(pend && lat >= 2); k++) step();
        chk("drain_setup", 32'(pend && lat >= 2), 32'd1);
        do_redirect(32'h102);
        wait_valid("drain_wait");
        chk("drain_new_addr", (issued_q.size() > 0) ? issued_q[0] : 32'hFFFF_FFFF, 32'h100);
        chk("drain_first_pc", inst_pc, 32'h102);
        repeat (10) step();

        // Redirect coinciding with an ack and a pop.
        lat_mode = 0;
        for (int k = 0; k < 20 && !(mem_ack && inst_valid && q_count != '0); k++) step();
        chk("coinc_setup", 32'(mem_ack && inst_valid), 32'd1);
        do_redirect(32'h200);
        #1;
        chk("coinc_valid_low", 32'(inst_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("coinc_flush", 32'(q_count), 32'd0);
        drive();
        repeat (10) step();

        // Random traffic.
        lat_mode  = 1;
        ready_pct = 70;
        redir_pct = 3;
        repeat (3000) step();
        redir_pct = 0;
        ready_pct = 100;
        repeat (20) step();

        // Reset during an outstanding request.
        lat_mode = 2;
        for (int k = 0; k < 20 && !(pend && lat >= 2); k++) step();
        chk("rstw_setup", 32'(pend), 32'd1);
        rst = 1'b1;
        #1;
        chk("rstw_req", 32'(mem_req), 32'd0);
        chk("rstw_valid", 32'(inst_valid), 32'd0);
        chk("rstw_count", 32'(q_count), 32'd0);
        repeat (4) step();
        @(posedge clk);
        #1;
        rst = 1'b0;
        restart(32'h0);
        issued_q.delete();
        #1;
        chk("rstw_restart_req", 32'(mem_req), 32'd1);
        chk("rstw_restart_addr", mem_addr, 32'h0);
        chk("rstw_restart_count", 32'(q_count), 32'd0);
        lat_mode = 1;
        drive();
        repeat (60) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

Parametrised instruction prefetch queue for the pipelined RISC-V core. It sits between the instruction memory port and the IF/ID register. It fetches aligned 32-bit words through a req/ack handshake and buffers them as halfwords in a DEPTH-entry circular queue. It hands decode one RV32C (16-bit) or RV32I (32-bit) instruction per cycle, including 32-bit instructions that span two words. Branch/jump redirects from the branch unit flush the queue and restart fetch at any halfword-aligned PC. Stale in-flight responses are discarded.

## Interface
- AW, 32: fetch address width.
- DEPTH, 8: queue capacity in halfwords; power of two, ≥4.
- RESET_PC, 0: first fetch address; bit 0 ignored.

Ports:
- clk  in  1  sole clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- mem_req  out  1  fetch request.
- mem_addr  out  AW  word address of the request; bits [1:0] always 0.
- mem_ack  in  1  response strobe; mem_rdata is valid in the same cycle.
- mem_rdata  in  32  fetched word; halfword at addr in [15:0], addr+2 in [31:16].
- redirect_valid  in  1  flush and restart request.
- redirect_pc  in  AW  restart PC; halfword aligned.
- inst_valid  out  1  inst_out, inst_pc and inst_is_c are valid.
- inst_ready  in  1  decode accepts the instruction.
- inst_out  out  32  instruction; for compressed, {16'h0000, halfword}.
- inst_pc  out  AW  PC of inst_out.
- inst_is_c  out  1  head halfword[1:0] != 2'b11.
- q_count  out  $clog2(DEPTH+1)  occupied halfwords, for debug.

## Operation
- Queue: circular halfword array with head/tail pointers modulo DEPTH and a count. Push and pop in the same cycle are both applied.
- FSM states:
  - RUN: no request outstanding.
  - WAIT: request outstanding, response wanted.
  - DRAIN: request outstanding, response stale.
- mem_req is 1 in RUN when free (DEPTH−q_count) ≥ 2, and always 1 in WAIT and DRAIN. It is 0 while rst is high.
- mem_addr and mem_req are held stable until mem_ack. At most one request is outstanding.
- RUN: if mem_req and mem_ack in the same cycle, the request completes immediately. If mem_req and no mem_ack, go to WAIT.
- WAIT: on mem_ack, push the response and go to RUN.
- Response push:
  - If the skip flag is set, push only rdata[31:16] and clear skip.
  - Otherwise push rdata[15:0] then rdata[31:16].
  - fetch_addr += 4 on every completed request, wrapping modulo 2^AW.
- Issue guard: free ≥ 2 is checked at issue time. Pops only add space, so a push never overflows.
- Decode output:
  - Head halfword h0 is at inst_pc.
  - inst_valid = count≥1 and (h0 compressed, or count≥2).
  - A 32-bit instruction is {h1,h0}.
  - On inst_valid & inst_ready, pop 1 or 2 halfwords and advance inst_pc by 2 or 4.
- Redirect (highest priority), applied at the edge on which it is sampled:
  - Clear the queue.
  - inst_pc ← redirect_pc.
  - fetch_addr ← {redirect_pc[AW-1:2], 2'b00}.
  - skip ← redirect_pc[1].
  - Any mem_ack in that cycle is discarded, and the pop is cancelled.
  - Next state:
    - If a request was outstanding and not acked this cycle, go to DRAIN. The old mem_addr is held.
    - Otherwise go to RUN.
  - inst_valid is forced 0 while redirect_valid is high.
- DRAIN: on mem_ack, discard the data without advancing fetch_addr, then go to RUN. A new redirect in DRAIN updates the target and keeps the state DRAIN.

## Timing
- Reset values:
  - mem_req 0; mem_addr RESET_PC & ~3.
  - inst_valid 0; inst_pc RESET_PC; inst_out 0; inst_is_c 0.
  - q_count 0; state RUN; skip RESET_PC[1].
- First cycle after reset release: mem_req=1 at RESET_PC.
- Zero-wait memory (ack in the request cycle): inst_valid rises the next cycle, i.e. 1 cycle of fetch latency.
- Throughput:
  - Sustains one 32-bit instruction per cycle with zero-wait memory when DEPTH ≥ 4.
  - Compressed streams fill the queue. Fetch throttles whenever fewer than 2 slots are free.
- Redirect to the first valid instruction:
  - Fetch at the new address is issued the cycle after the redirect.
  - inst_valid follows 1 cycle after its ack, or 2 if the target is an unaligned 32-bit instruction.
  - Add the remaining latency of a stale response if in DRAIN.
- Boundary cases:
  - Full queue: no request issued.
  - Empty queue, or a lone upper-half-of-32-bit halfword: inst_valid=0.
  - Pointer wrap: must be transparent, including a 32-bit instruction whose halves straddle entry DEPTH−1 and entry 0.

## Test plan
- Reset with RESET_PC=0, zero-wait memory returning words 0x00500093, 0x00A00113 → mem_req=1 in cycle 0; inst_valid in cycle 1 with inst_out=0x00500093, inst_pc=0; inst_pc=4 in cycle 2.
- Mixed stream: word 0x0093_4505 (c.li at 0, then low half of a 32-bit instruction at 2), next word 0x1234_0050 → inst 0x00004505 (is_c=1, pc 0), then 0x00500093 (pc 2, spans words).
- inst_ready=0 with DEPTH=8 → q_count saturates at 8; mem_req drops at q_count 7 or 8; no overflow and no lost data after ready returns.
- Redirect to 0x102 while memory holds ack 3 cycles → DRAIN; stale word discarded; next mem_addr=0x100; first inst_pc=0x102 using rdata[31:16].
- Redirect in the same cycle as mem_ack and inst_ready → response discarded, no pop, q_count=0 next cycle, inst_valid=0 during redirect.
- Assert rst mid-WAIT → mem_req and inst_valid go to 0 immediately; after release, fetch restarts at RESET_PC and the late ack is not pushed.
